// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - instruction memory req/ack bus between fetch stage and imem
//
// Purpose: bundles the fetch request/response handshake into one port.
// Signals:
//   req   fetch request valid (fetch stage -> memory)
//   addr  fetch address, ADDR_W bits (fetch stage -> memory)
//   ack   memory returns data for the current addr this cycle (memory -> fetch stage)
//   data  fetched instruction word, INSTR_W bits (memory -> fetch stage)
// Modports: master = fetch stage, slave = instruction memory.
interface if_fetch_stage_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               ack;
  logic [INSTR_W-1:0] data;

  modport master (output req, output addr, input ack, input data);
  modport slave  (input req, input addr, output ack, output data);
endinterface

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage with IF/ID register, skid buffer and branch flush
//
// Purpose: holds the PC, fetches from instruction memory over a req/ack handshake,
// and registers each returned word into the IF/ID output register feeding the decoder.
// A one-entry skid buffer absorbs a word acked while the output register is stalled.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   imem               instruction memory bus (master modport: req, addr, ack, data)
//   stall_i            downstream cannot accept; output register holds
//   branch_i           one-cycle redirect pulse, branch_target_i is the new PC
//   valid_o            IF/ID register holds a valid instruction
//   instr_o, pc_o      registered instruction and its address
//   instr_op_o         opcode field of instr_o
//   pc_plus4_o         pc_o + 4 (modulo 2^ADDR_W)
//   fetch_cnt_o        loaded-instruction counter, present only with IF_FETCH_CNT_EN
// Optional feature macro: IF_FETCH_CNT_EN
module if_fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  if_fetch_stage_if.master   imem,
  input  logic               stall_i,
  input  logic               branch_i,
  input  logic [ADDR_W-1:0]  branch_target_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [5:0]         instr_op_o,
  output logic [ADDR_W-1:0]  pc_o,
`ifdef IF_FETCH_CNT_EN
  output logic [31:0]        fetch_cnt_o,
`endif
  output logic [ADDR_W-1:0]  pc_plus4_o
);

  localparam logic [0:0] S_REQ  = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]         state;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] skid_instr;
  logic [ADDR_W-1:0]  skid_pc;
  logic               out_free;
  logic               load_out;

  // S_HOLD is exactly "skid full", so no separate skid valid flag is kept.
  assign out_free   = !valid_o || !stall_i;
  assign imem.req   = (state == S_REQ) && !rst_i;
  assign imem.addr  = pc;
  assign instr_op_o = instr_o[INSTR_W-1 -: 6];
  assign pc_plus4_o = pc_o + ADDR_W'(4);

  // High on every cycle the output register takes a new instruction (direct or from skid).
  assign load_out = !rst_i && !branch_i &&
                    (((state == S_REQ) && imem.ack && out_free) ||
                     ((state == S_HOLD) && !stall_i));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc         <= RESET_PC;
      state      <= S_REQ;
      valid_o    <= 1'b0;
      instr_o    <= '0;
      pc_o       <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else if (branch_i) begin
      // Flush: discard any same-cycle ack and the skid content.
      pc         <= {branch_target_i[ADDR_W-1:2], 2'b00};
      state      <= S_REQ;
      valid_o    <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (imem.ack) begin
            pc <= pc + ADDR_W'(4);
            if (out_free) begin
              instr_o <= imem.data;
              pc_o    <= pc;
              valid_o <= 1'b1;
            end else begin
              skid_instr <= imem.data;
              skid_pc    <= pc;
              state      <= S_HOLD;
            end
          end else if (out_free) begin
            valid_o <= 1'b0;
          end
        end
        default: begin
          if (!stall_i) begin
            instr_o    <= skid_instr;
            pc_o       <= skid_pc;
            valid_o    <= 1'b1;
            skid_instr <= '0;
            skid_pc    <= '0;
            state      <= S_REQ;
          end
        end
      endcase
    end
  end

`ifdef IF_FETCH_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_cnt_o <= '0;
    end else if (load_out) begin
      fetch_cnt_o <= fetch_cnt_o + 32'd1;
    end
  end
`else
  logic unused_load;
  assign unused_load = load_out;
`endif

endmodule
